instruction_sequencer: RTL and testbench

//  Program-counter controller for the 28-bit instruction ROM. Drives the ROM address, captures the

---
 rtl/instruction_sequencer_pkg.sv | 29 ++
 rtl/instruction_sequencer_if.sv | 22 ++
 rtl/instruction_sequencer_delay.sv | 28 ++
 rtl/instruction_sequencer.sv | 128 ++++++++++++
 tb/tb_instruction_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer:
// widths, opcode values and instruction field positions.
package instruction_sequencer_pkg;

   localparam int PC_W    = 16;
   localparam int INSN_W  = 28;
   localparam int DELAY_W = 24;

   localparam int OP_HI = 27;
   localparam int OP_LO = 24;
   localparam int A_HI  = 23;
   localparam int A_LO  = 16;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_JMP = 4'd1,
      OP_BLE = 4'd2,
      OP_STO = 4'd3,
      OP_ADD = 4'd4,
      OP_SUB = 4'd5,
      OP_LD  = 4'd6
   } op_e;

   // Branch and jump targets are 8-bit and zero-extended.
   function automatic logic [PC_W-1:0] target(input logic [7:0] a);
      return {{(PC_W-8){1'b0}}, a};
   endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Issue handshake between the sequencer and the execute stage,
// plus the branch-resolution return path.
interface instruction_sequencer_if;
   import instruction_sequencer_pkg::*;

   logic [INSN_W-1:0] insn;
   logic              valid;
   logic              ready;
   logic              br_valid;
   logic              br_taken;

   modport master (
      output insn, valid,
      input  ready, br_valid, br_taken
   );

   modport slave (
      input  insn, valid,
      output ready, br_valid, br_taken
   );

endinterface

// File: rtl/instruction_sequencer_delay.sv
// NOP delay counter: load N, count down, flag the last cycle.
// done is high while the count sits at 1.
module nop_delay_counter #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] n,
   input  logic         dec,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= n;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == W'(1));

endmodule

// File: rtl/instruction_sequencer.sv
// Program-counter controller: fetches from a combinational ROM,
// resolves NOP/JMP locally, issues the rest and waits on BLE.
module instruction_sequencer
   import instruction_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   output logic [PC_W-1:0]     address,
   input  logic [INSN_W-1:0]   instruction,
   output logic                busy,
   instruction_sequencer_if.master ex
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      ISSUE   = 2'd1,
      BR_WAIT = 2'd2,
      DELAY   = 2'd3
   } state_e;

   state_e              state;
   logic [PC_W-1:0]     pc;
   logic [INSN_W-1:0]   ir;
   logic                valid_q;
   logic                busy_q;

   logic [3:0]          op;
   logic [DELAY_W-1:0]  n;
   logic                is_nop;
   logic                is_jmp;
   logic                n_zero;
   logic                ir_ble;
   logic                dly_load;
   logic                dly_dec;
   logic                dly_done;

   assign op     = instruction[OP_HI:OP_LO];
   assign n      = instruction[DELAY_W-1:0];
   assign is_nop = (op == OP_NOP);
   assign is_jmp = (op == OP_JMP);
   assign n_zero = (n == '0);
   assign ir_ble = (ir[OP_HI:OP_LO] == OP_BLE);

   assign dly_load = (state == FETCH) && enable
                   && is_nop && !n_zero;
   assign dly_dec  = (state == DELAY);

   nop_delay_counter #(
      .W (DELAY_W)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .load (dly_load),
      .n    (n),
      .dec  (dly_dec),
      .done (dly_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= FETCH;
         pc      <= '0;
         ir      <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (enable) begin
                  unique case (1'b1)
                     is_nop && n_zero: pc <= pc + 1'b1;
                     is_nop && !n_zero: begin
                        state  <= DELAY;
                        busy_q <= 1'b1;
                     end
                     is_jmp: pc <= target(instruction[A_HI:A_LO]);
                     default: begin
                        ir      <= instruction;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= ISSUE;
                     end
                  endcase
               end
            end
            DELAY: begin
               if (dly_done) begin
                  pc     <= pc + 1'b1;
                  busy_q <= 1'b0;
                  state  <= FETCH;
               end
            end
            ISSUE: begin
               // a branch result arriving with the handshake is dropped
               if (ex.ready) begin
                  valid_q <= 1'b0;
                  if (ir_ble) begin
                     state <= BR_WAIT;
                  end else begin
                     pc     <= pc + 1'b1;
                     busy_q <= 1'b0;
                     state  <= FETCH;
                  end
               end
            end
            BR_WAIT: begin
               if (ex.br_valid) begin
                  pc <= ex.br_taken ? target(ir[A_HI:A_LO])
                                    : pc + 1'b1;
                  busy_q <= 1'b0;
                  state  <= FETCH;
               end
            end
            default: begin
               state  <= FETCH;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign address  = pc;
   assign busy     = busy_q;
   assign ex.insn  = ir;
   assign ex.valid = valid_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: a ROM model drives
// fetches, expected per-cycle outputs are queued and compared.
module tb_instruction_sequencer;
   import instruction_sequencer_pkg::*;

   typedef struct packed {
      logic [15:0] addr;
      logic        valid;
      logic        busy;
      logic [27:0] insn;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [15:0] address;
   logic [27:0] instruction;
   logic        busy;
   logic [27:0] rom [0:65535];

   exp_t sb[$];
   exp_t e;
   int   checks;
   int   failures;

   instruction_sequencer_if ex ();

   instruction_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .address     (address),
      .instruction (instruction),
      .busy        (busy),
      .ex          (ex.master)
   );

   assign instruction = rom[address];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic clear_rom();
      for (int i = 0; i < 65536; i++) rom[i] = '0;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      enable      = 1'b0;
      ex.ready    = 1'b0;
      ex.br_valid = 1'b0;
      ex.br_taken = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [27:0] jmp(input logic [7:0] a);
      return {OP_JMP, a, 16'd0};
   endfunction

   task automatic test_reset();
      clear_rom();
      rom[0] = {OP_STO, 8'd2, 16'd1};
      rst = 1'b1;
      enable = 1'b1;
      ex.ready = 1'b1;
      ex.br_valid = 1'b0;
      ex.br_taken = 1'b0;
      repeat (2) sb.push_back('{16'h0, 1'b0, 1'b0, 28'h0});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL reset: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
      rst = 1'b0;
      enable = 1'b0;
      ex.ready = 1'b0;
   endtask

   task automatic test_nop_delay();
      clear_rom();
      rom[0] = {OP_NOP, 24'd3};
      rom[1] = jmp(8'd1);
      do_reset();
      checks++;
      if (address !== 16'h0 || ex.valid !== 1'b0) begin
         failures++;
         $display("FAIL nop_start: got a=%h v=%b want a=0000 v=0",
            address, ex.valid);
      end
      enable = 1'b1;
      repeat (3) sb.push_back('{16'h0, 1'b0, 1'b1, 28'h0});
      repeat (2) sb.push_back('{16'h1, 1'b0, 1'b0, 28'h0});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL nop_delay: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_stall();
      logic [27:0] w;
      w = {OP_STO, 8'd2, 16'd1};
      clear_rom();
      rom[0] = w;
      rom[1] = jmp(8'd1);
      do_reset();
      enable = 1'b1;
      repeat (5) sb.push_back('{16'h0, 1'b1, 1'b1, w});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL stall_hold: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
      ex.ready = 1'b1;
      repeat (2) sb.push_back('{16'h1, 1'b0, 1'b0, w});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL stall_release: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
      enable = 1'b0;
      ex.ready = 1'b0;
   endtask

   task automatic test_branch();
      logic [27:0] b;
      b = {OP_BLE, 8'd11, 8'd7, 8'd5};
      clear_rom();
      rom[0]  = jmp(8'd12);
      rom[12] = b;
      rom[11] = jmp(8'd11);
      rom[13] = jmp(8'd13);
      // taken, with the result arriving late
      do_reset();
      enable = 1'b1;
      ex.ready = 1'b1;
      sb.push_back('{16'd12, 1'b0, 1'b0, 28'h0});
      sb.push_back('{16'd12, 1'b1, 1'b1, b});
      repeat (2) sb.push_back('{16'd12, 1'b0, 1'b1, b});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL ble_wait: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
      ex.br_valid = 1'b1;
      ex.br_taken = 1'b1;
      repeat (2) sb.push_back('{16'd11, 1'b0, 1'b0, b});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL ble_taken: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
      // not taken; br_valid held high from the start must be
      // ignored in FETCH and in the ISSUE handshake cycle
      do_reset();
      enable = 1'b1;
      ex.ready = 1'b1;
      ex.br_valid = 1'b1;
      ex.br_taken = 1'b0;
      sb.push_back('{16'd12, 1'b0, 1'b0, 28'h0});
      sb.push_back('{16'd12, 1'b1, 1'b1, b});
      sb.push_back('{16'd12, 1'b0, 1'b1, b});
      repeat (2) sb.push_back('{16'd13, 1'b0, 1'b0, b});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL ble_not_taken: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
      enable = 1'b0;
      ex.ready = 1'b0;
      ex.br_valid = 1'b0;
   endtask

   task automatic test_jmp();
      clear_rom();
      rom[0]  = jmp(8'd18);
      rom[18] = jmp(8'd4);
      rom[4]  = jmp(8'd4);
      do_reset();
      enable = 1'b1;
      ex.ready = 1'b1;
      sb.push_back('{16'd18, 1'b0, 1'b0, 28'h0});
      repeat (3) sb.push_back('{16'd4, 1'b0, 1'b0, 28'h0});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL jmp: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
      enable = 1'b0;
      ex.ready = 1'b0;
   endtask

   task automatic test_wrap();
      logic [27:0] w;
      int          n;
      w = {OP_ADD, 8'd1, 8'd2, 8'd3};
      clear_rom();
      rom[16'hFFFF] = w;
      do_reset();
      enable = 1'b1;
      ex.ready = 1'b1;
      n = 0;
      while (address !== 16'hFFFF && n < 70000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (address !== 16'hFFFF) begin
         failures++;
         $display("FAIL wrap_reach: got a=%h want a=ffff after %0d cycles",
            address, n);
      end
      sb.push_back('{16'hFFFF, 1'b1, 1'b1, w});
      sb.push_back('{16'h0000, 1'b0, 1'b0, w});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL wrap: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
      enable = 1'b0;
      ex.ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [27:0] w;
      w = {OP_ADD, 8'd9, 8'd8, 8'd7};
      clear_rom();
      rom[0] = jmp(8'd7);
      rom[7] = {OP_NOP, 24'd4000};
      // reset in the middle of a long delay
      do_reset();
      enable = 1'b1;
      sb.push_back('{16'd7, 1'b0, 1'b0, 28'h0});
      repeat (11) sb.push_back('{16'd7, 1'b0, 1'b1, 28'h0});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL mid_delay: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({address, ex.valid, busy, ex.insn} !== {16'h0, 1'b0, 1'b0, 28'h0}) begin
         failures++;
         $display("FAIL delay_reset: got a=%h v=%b b=%b i=%h want a=0000 v=0 b=0 i=0000000",
            address, ex.valid, busy, ex.insn);
      end
      // reset while an issue is stalled
      rom[7] = w;
      ex.ready = 1'b0;
      sb.push_back('{16'd7, 1'b0, 1'b0, 28'h0});
      repeat (2) sb.push_back('{16'd7, 1'b1, 1'b1, w});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL mid_issue: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
      rst = 1'b1;
      sb.push_back('{16'h0, 1'b0, 1'b0, 28'h0});
      e = sb.pop_front();
      @(posedge clk);
      #1;
      checks++;
      if ({address, ex.valid, busy, ex.insn} !== e) begin
         failures++;
         $display("FAIL issue_reset: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
            address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
      end
      // disabled at FETCH: JMP at address 0 must not be taken
      rst = 1'b0;
      enable = 1'b0;
      repeat (4) sb.push_back('{16'h0, 1'b0, 1'b0, 28'h0});
      while (sb.size() != 0) begin
         e = sb.pop_front();
         @(posedge clk);
         #1;
         checks++;
         if ({address, ex.valid, busy, ex.insn} !== e) begin
            failures++;
            $display("FAIL enable_freeze: got a=%h v=%b b=%b i=%h want a=%h v=%b b=%b i=%h",
               address, ex.valid, busy, ex.insn, e.addr, e.valid, e.busy, e.insn);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst         = 1'b1;
      enable      = 1'b0;
      ex.ready    = 1'b0;
      ex.br_valid = 1'b0;
      ex.br_taken = 1'b0;
      clear_rom();
      test_reset();
      test_nop_delay();
      test_stall();
      test_branch();
      test_jmp();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
